fib_sequencer: RTL and testbench
================================

# fib_sequencer

Multi-cycle controller that owns the Fibonacci scratch RAM and adder of the extended MU0 datapath. On a start request from the MU0 control unit it fills the RAM iteratively with fib(0..N), returns fib(N) in a result register, and holds the CPU in EXEC2 until done. It replaces the combinational per-PC condition logic with an explicit FSM, index counter and start/done handshake. Convention: fib(0) = fib(1) = 1.

## Interface
- DATA_W, 16, width of Fibonacci values and of the N operand
- ADDR_W, 12, scratch RAM address width; largest legal N is 2^ADDR_W − 1
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- fib_start  in  1  request pulse; sampled only in IDLE
- fib_n  in  DATA_W  index N, from IR operand; sampled with fib_start
- fib_abort  in  1  synchronous cancel of a running computation
- fib_busy  out  1  high in every state except IDLE and DONE; MU0 FSM stays in EXEC2 while high
- fib_done  out  1  one-cycle pulse, result valid
- fib_result  out  DATA_W  fib(N) modulo 2^DATA_W
- fib_ovf  out  1  some fib(i), i ≤ N, exceeded 2^DATA_W − 1
- fib_err  out  1  N out of address range; no computation done
- ram_addr_a  out  ADDR_W  port A address (read/write)
- ram_data_a  out  DATA_W  port A write data
- ram_wren_a  out  1  port A write enable
- ram_addr_b  out  ADDR_W  port B address (read only)
- ram_q_a, ram_q_b  in  DATA_W  registered read data, valid one cycle after address

## Operation
- States: IDLE, INIT0, INIT1, RD, WR, DONE. Index counter i (ADDR_W bits), latched N.
- IDLE: on fib_start=1 and fib_abort=0, latch N, clear fib_ovf/fib_err:
  - N > 2^ADDR_W − 1 → DONE, fib_err=1, fib_result=0.
  - N ≤ 1 → DONE, fib_result=1.
  - else → INIT0.
- INIT0: write addr 0 ← 1. → INIT1.
- INIT1: write addr 1 ← 1; i ← 2. → RD.
- RD: ram_addr_a=i−2, ram_addr_b=i−1, ram_wren_a=0. → WR.
- WR: sum = ram_q_a + ram_q_b computed in DATA_W+1 bits; write addr i ← sum[DATA_W−1:0]; carry sets fib_ovf (sticky until next accepted start). If i == N: fib_result ← sum, → DONE; else i ← i+1, → RD.
- DONE: fib_done=1 for exactly this cycle. → IDLE.
- fib_abort=1 in INIT0/INIT1/RD/WR: → IDLE next edge, no fib_done, fib_result/flags keep previous values; RAM contents undefined.
- fib_start while busy or in DONE is ignored (no queueing). fib_start and fib_abort together in IDLE: abort wins, start dropped.
- ram_wren_a=0 outside INIT0, INIT1, WR; idle addresses are 0.
- fib_result, fib_ovf, fib_err are stable from DONE until the next accepted start.

## Timing
- Reset (async, rst_n=0): state IDLE, i=0, all outputs 0 (fib_busy, fib_done, fib_result, fib_ovf, fib_err, ram_* = 0).
- Start accepted at edge k. Done pulse occupies the cycle after edge k+L:
  - N ≤ 1 or fib_err: L = 1.
  - 2 ≤ N ≤ 4095: L = 2N + 1 (2 init + 2 per index + DONE).
- fib_busy rises in the cycle after edge k (N ≥ 2 only) and falls in the DONE cycle.
- Back-to-back: next fib_start is accepted in the IDLE cycle following DONE at the earliest.
- RAM read latency is exactly 1 cycle; controller never reads an address in the same cycle it is written.
- Overflow: fib(23)=46368 fits; fib(24)=75025 sets fib_ovf, fib_result = 9489.

## Test plan
- Reset mid-RD with N=10 → all outputs 0 immediately; next start N=5 → result 8, done 11 cycles after accept.
- N=0 and N=1 → fib_done 1 cycle after accept, result 1, fib_busy never high, no RAM writes.
- N=2 → writes addr0=1, addr1=1, addr2=2; result 2, done at L=5; N=10 → result 89, L=21, RAM[10]=89.
- N=24 → fib_ovf=1, result 9489; following N=23 → fib_ovf=0, result 46368.
- N=4096 → fib_err=1, result 0, L=1, no RAM writes; N=4095 runs to completion (L=8191) with ovf=1.
- fib_abort in WR for N=20 → IDLE, no done, previous result held; fib_start during busy ignored; start+abort in IDLE → not accepted.

Source files
------------

// File: rtl/fib_sequencer.sv
// fib_sequencer: multi-cycle Fibonacci engine for the extended MU0 datapath.
// Fills a dual-port scratch RAM with fib(0..N) (fib(0) = fib(1) = 1) using
// one adder. It reads two earlier terms, then writes their sum, and returns
// fib(N) through a start/done handshake. fib_busy holds the CPU in EXEC2
// while a computation is running.
module fib_sequencer #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fib_start,
   input  logic [DATA_W-1:0] fib_n,
   input  logic              fib_abort,
   output logic              fib_busy,
   output logic              fib_done,
   output logic [DATA_W-1:0] fib_result,
   output logic              fib_ovf,
   output logic              fib_err,
   output logic [ADDR_W-1:0] ram_addr_a,
   output logic [DATA_W-1:0] ram_data_a,
   output logic              ram_wren_a,
   output logic [ADDR_W-1:0] ram_addr_b,
   input  logic [DATA_W-1:0] ram_q_a,
   input  logic [DATA_W-1:0] ram_q_b
);

   // N and the index counter can differ in width, so both are compared in a
   // common width that holds either one without truncation.
   localparam int CMP_W = DATA_W + ADDR_W;
   localparam logic [CMP_W-1:0] MAX_N = {{DATA_W{1'b0}}, {ADDR_W{1'b1}}};

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      INIT0 = 3'd1,
      INIT1 = 3'd2,
      RD    = 3'd3,
      WR    = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [ADDR_W-1:0] idx;
   logic [DATA_W-1:0] n_lat;
   logic [DATA_W-1:0] result;
   logic              ovf;
   logic              err;

   logic              accept;
   logic              n_big;
   logic              n_small;
   logic              at_last;
   logic [DATA_W:0]   sum;

   // A start counts only in IDLE. An abort in the same cycle wins.
   assign accept  = (state == IDLE) && fib_start && !fib_abort;

   // An N beyond the RAM cannot be computed. N of 0 or 1 needs no RAM work.
   assign n_big   = CMP_W'(fib_n) > MAX_N;
   assign n_small = fib_n <= DATA_W'(1);

   // The final write happens when the index reaches the latched N.
   assign at_last = CMP_W'(idx) == CMP_W'(n_lat);

   // The extra top bit is the carry that marks a term wider than DATA_W.
   assign sum = {1'b0, ram_q_a} + {1'b0, ram_q_b};

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. An abort pulls any working state back to IDLE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (n_big || n_small) begin
                  state_next = DONE;
               end else begin
                  state_next = INIT0;
               end
            end
         end
         INIT0: state_next = fib_abort ? IDLE : INIT1;
         INIT1: state_next = fib_abort ? IDLE : RD;
         RD:    state_next = fib_abort ? IDLE : WR;
         WR: begin
            if (fib_abort) begin
               state_next = IDLE;
            end else if (at_last) begin
               state_next = DONE;
            end else begin
               state_next = RD;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Moore outputs: handshake flags and RAM port control decoded from the state
   always_comb begin
      fib_busy   = 1'b0;
      fib_done   = 1'b0;
      ram_addr_a = '0;
      ram_data_a = '0;
      ram_wren_a = 1'b0;
      ram_addr_b = '0;
      case (state)
         INIT0: begin
            fib_busy   = 1'b1;
            ram_addr_a = '0;
            ram_data_a = DATA_W'(1);
            ram_wren_a = 1'b1;
         end
         INIT1: begin
            fib_busy   = 1'b1;
            ram_addr_a = ADDR_W'(1);
            ram_data_a = DATA_W'(1);
            ram_wren_a = 1'b1;
         end
         RD: begin
            // These are the two preceding terms. Their data arrives in WR.
            fib_busy   = 1'b1;
            ram_addr_a = idx - ADDR_W'(2);
            ram_addr_b = idx - ADDR_W'(1);
         end
         WR: begin
            // Port A writes address i. No read is issued this cycle, so the
            // controller never reads an address while it is being written.
            fib_busy   = 1'b1;
            ram_addr_a = idx;
            ram_data_a = sum[DATA_W-1:0];
            ram_wren_a = 1'b1;
         end
         DONE: begin
            fib_done = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Datapath: latched N, index counter, result and sticky status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx    <= '0;
         n_lat  <= '0;
         result <= '0;
         ovf    <= 1'b0;
         err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  n_lat <= fib_n;
                  ovf   <= 1'b0;
                  err   <= n_big;
                  // For N >= 2, result keeps its old value until the final
                  // write, so an abort leaves the previous answer in place.
                  if (n_big) begin
                     result <= '0;
                  end else if (n_small) begin
                     result <= DATA_W'(1);
                  end
               end
            end
            INIT1: begin
               idx <= ADDR_W'(2);
            end
            WR: begin
               if (!fib_abort) begin
                  if (sum[DATA_W]) begin
                     ovf <= 1'b1;
                  end
                  if (at_last) begin
                     result <= sum[DATA_W-1:0];
                  end else begin
                     idx <= idx + ADDR_W'(1);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign fib_result = result;
   assign fib_ovf    = ovf;
   assign fib_err    = err;

endmodule

// File: tb/tb_fib_sequencer.sv
// Testbench for fib_sequencer: a behavioural dual-port RAM, directed cases
// and a randomized transaction mix, checked against a plain-arithmetic
// Fibonacci model.
module tb_fib_sequencer;

   localparam int DW = 16;
   localparam int AW = 12;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          fib_start;
   logic [DW-1:0] fib_n;
   logic          fib_abort;
   logic          fib_busy;
   logic          fib_done;
   logic [DW-1:0] fib_result;
   logic          fib_ovf;
   logic          fib_err;
   logic [AW-1:0] ram_addr_a;
   logic [DW-1:0] ram_data_a;
   logic          ram_wren_a;
   logic [AW-1:0] ram_addr_b;
   logic [DW-1:0] ram_q_a = '0;
   logic [DW-1:0] ram_q_b = '0;

   int checks   = 0;
   int failures = 0;
   logic [DW-1:0] prev_res;

   always #5 clk = ~clk;

   fib_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fib_start  (fib_start),
      .fib_n      (fib_n),
      .fib_abort  (fib_abort),
      .fib_busy   (fib_busy),
      .fib_done   (fib_done),
      .fib_result (fib_result),
      .fib_ovf    (fib_ovf),
      .fib_err    (fib_err),
      .ram_addr_a (ram_addr_a),
      .ram_data_a (ram_data_a),
      .ram_wren_a (ram_wren_a),
      .ram_addr_b (ram_addr_b),
      .ram_q_a    (ram_q_a),
      .ram_q_b    (ram_q_b)
   );

   // Scratch RAM: one-cycle registered reads, read-before-write on port A
   logic [DW-1:0] mem [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (ram_wren_a) mem[ram_addr_a] <= ram_data_a;
      ram_q_a <= mem[ram_addr_a];
      ram_q_b <= mem[ram_addr_b];
   end

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Reference: true Fibonacci values to detect overflow, and mod 2^16 values for the result
   task automatic fib_model(input int n, output logic [DW-1:0] res, output bit ovf, output bit err);
      longint a, b, t;
      logic [DW-1:0] ma, mb, mt;
      bit big;
      big = 1'b0;
      err = (n > (1 << AW) - 1);
      ovf = 1'b0;
      res = err ? 16'd0 : 16'd1;
      if (!err && n >= 2) begin
         a = 1; b = 1; ma = 1; mb = 1;
         for (int i = 2; i <= n; i++) begin
            mt = ma + mb; ma = mb; mb = mt;
            if (!big) begin
               t = a + b; a = b; b = t;
               if (t > 65535) big = 1'b1;
            end
         end
         ovf = big;
         res = mb;
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"},   int'(fib_busy), 0);
      chk({tag, "_done"},   int'(fib_done), 0);
      chk({tag, "_result"}, int'(fib_result), 0);
      chk({tag, "_ovf"},    int'(fib_ovf), 0);
      chk({tag, "_err"},    int'(fib_err), 0);
      chk({tag, "_ram"},    int'({ram_addr_a, ram_data_a, ram_wren_a}), 0);
      chk({tag, "_addrb"},  int'(ram_addr_b), 0);
   endtask

   // One transaction. abort_at > 0 raises fib_abort during that busy cycle.
   // The poke flags pulse fib_start while the engine is busy or in DONE.
   task automatic run_fib(input int n, input int abort_at, input bit poke_busy, input bit poke_done);
      logic [DW-1:0] er, ma, mb, mt;
      bit eo, ee, done_seen, busy_seen, aborted, late_done;
      int exp_lat, lat, wr_cnt, max_cyc, bad;
      fib_model(n, er, eo, ee);
      exp_lat = (n <= 1 || ee) ? 1 : 2 * n + 1;
      max_cyc = exp_lat + 8;
      @(negedge clk);
      fib_n = DW'(n);
      fib_start = 1'b1;
      @(posedge clk); #1;
      fib_start = 1'b0;
      fib_n = DW'($urandom);
      lat = 1; wr_cnt = 0; done_seen = 0; busy_seen = 0; aborted = 0;
      forever begin
         if (ram_wren_a) wr_cnt++;
         if (fib_busy) busy_seen = 1'b1;
         if (fib_done) begin done_seen = 1'b1; break; end
         if (aborted || lat >= max_cyc) break;
         if (abort_at == lat) fib_abort = 1'b1;
         if (poke_busy && lat == 2) begin fib_start = 1'b1; fib_n = '0; end
         @(posedge clk); #1;
         fib_abort = 1'b0;
         fib_start = 1'b0;
         if (abort_at == lat) aborted = 1'b1;
         lat++;
      end
      if (abort_at > 0) begin
         chk("abort_no_done", int'(done_seen), 0);
         chk("abort_busy", int'(fib_busy), 0);
         chk("abort_result_held", int'(fib_result), int'(prev_res));
         chk("abort_err", int'(fib_err), 0);
         if (n < 24) chk("abort_ovf", int'(fib_ovf), 0);
         late_done = 1'b0;
         repeat (3) begin
            @(posedge clk); #1;
            if (fib_done) late_done = 1'b1;
         end
         chk("abort_late_done", int'(late_done), 0);
         $display("txn n=%0d aborted_at=%0d result=%0d", n, abort_at, fib_result);
         return;
      end
      chk("done_seen", int'(done_seen), 1);
      chk("latency", lat, exp_lat);
      chk("result", int'(fib_result), int'(er));
      chk("ovf", int'(fib_ovf), int'(eo));
      chk("err", int'(fib_err), int'(ee));
      chk("ram_writes", wr_cnt, (n <= 1 || ee) ? 0 : n + 1);
      chk("busy_seen", int'(busy_seen), (n <= 1 || ee) ? 0 : 1);
      if (n >= 2 && !ee) begin
         bad = 0; ma = 1; mb = 1;
         if (mem[0] !== 16'd1) bad++;
         if (mem[1] !== 16'd1) bad++;
         for (int k = 2; k <= n; k++) begin
            mt = ma + mb; ma = mb; mb = mt;
            if (mem[k] !== mt) bad++;
         end
         chk("ram_image_bad", bad, 0);
      end
      if (poke_done) begin fib_start = 1'b1; fib_n = '0; end
      @(posedge clk); #1;
      fib_start = 1'b0;
      chk("done_one_cycle", int'(fib_done), 0);
      chk("idle_after_done", int'(fib_busy), 0);
      chk("result_stable", int'(fib_result), int'(er));
      prev_res = er;
      $display("txn n=%0d lat=%0d result=%0d ovf=%0b err=%0b", n, lat, fib_result, fib_ovf, fib_err);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, ab;
      rst_n = 1'b0; fib_start = 1'b0; fib_abort = 1'b0; fib_n = '0;
      prev_res = '0;
      #12;
      chk_all_zero("reset");
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Reset asserted while the engine sits in RD with N=10
      fib_n = 16'd10; fib_start = 1'b1;
      @(posedge clk); #1; fib_start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rd_busy", int'(fib_busy), 1);
      chk("rd_wren", int'(ram_wren_a), 0);
      chk("rd_addr_a", int'(ram_addr_a), 0);
      chk("rd_addr_b", int'(ram_addr_b), 1);
      #2; rst_n = 1'b0; #1;
      chk_all_zero("midrst");
      $display("txn reset asserted during RD n=10");
      @(negedge clk); rst_n = 1'b1;
      prev_res = '0;

      run_fib(5, 0, 0, 0);
      run_fib(0, 0, 0, 0);
      run_fib(1, 0, 0, 0);
      run_fib(2, 0, 0, 0);
      run_fib(10, 0, 0, 0);
      run_fib(24, 0, 0, 0);
      run_fib(23, 0, 0, 0);
      run_fib(4096, 0, 0, 0);
      run_fib(65535, 0, 0, 0);
      run_fib(7, 0, 0, 0);
      run_fib(20, 10, 0, 0);
      run_fib(9, 0, 1, 1);

      // Start together with abort in IDLE must be dropped
      @(negedge clk); fib_n = 16'd0; fib_start = 1'b1; fib_abort = 1'b1;
      @(posedge clk); #1; fib_start = 1'b0; fib_abort = 1'b0;
      chk("start_abort_n0_done", int'(fib_done), 0);
      @(negedge clk); fib_n = 16'd5; fib_start = 1'b1; fib_abort = 1'b1;
      @(posedge clk); #1; fib_start = 1'b0; fib_abort = 1'b0;
      chk("start_abort_n5_busy", int'(fib_busy), 0);
      $display("txn start+abort in IDLE dropped");

      run_fib(4095, 0, 0, 0);

      for (int t = 0; t < 25; t++) begin
         case ($urandom_range(0, 9))
            0, 1:    n = $urandom_range(0, 3);
            8:       n = $urandom_range(61, 300);
            9:       n = $urandom_range(4096, 65535);
            default: n = $urandom_range(2, 60);
         endcase
         ab = 0;
         if (n >= 2 && n <= 4095 && $urandom_range(0, 3) == 0) ab = $urandom_range(1, 2 * n);
         run_fib(n, ab, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
